usb_fifo_bridge: RTL
====================

USB_FIFO_BRIDGE -- requirements
Module: usb_fifo_bridge

Interface
REQ-001 Parameter OUT_EP_ADR, default 2'b00: FIFOADR code of the host-to-device endpoint (EP2) that is read.
REQ-002 Parameter IN_EP_ADR, default 2'b10: FIFOADR code of the device-to-host endpoint (EP6) that is written.
REQ-003 CLK  in  1  sole clock; same clock as the FX2 IFCLK; all logic on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 WEnable  in  1  client write request, level.
REQ-006 WCnt  in  10  number of words to write, sampled on transaction start.
REQ-007 Send  in  16  write word offered by the client.
REQ-008 WDone  out  1  one-cycle pulse per word taken from Send.
REQ-009 REnable  in  1  client read request, level.
REQ-010 RCnt  in  10  number of words to read, sampled on transaction start.
REQ-011 Receive  out  16  last word read from the FX2; held until the next read.
REQ-012 RReady  out  1  one-cycle pulse, coincident with the Receive update.
REQ-013 FD_In / FD_Out / FD_OE  in 16 / out 16 / out 1  FX2 data bus, split form; the pad tristate sits at top level.
REQ-014 FIFOADR  out  2  endpoint select.
REQ-015 SLWR_N, SLRD_N, SLOE_N, PKTEND_N  out  1 each  FX2 strobes, active-low.
REQ-016 FullN, EmptyN  in  1 each  FX2 flags: IN endpoint not full, OUT endpoint not empty.

Function
REQ-017 All outputs SHALL be registered; the FSM states SHALL be IDLE, W_ADR, W_DATA, W_GAP, W_END, R_ADR, R_OE, R_DATA, R_GAP, HOLD.
REQ-018 IDLE SHALL sample WEnable first; a write has priority when WEnable and REnable are both high.
REQ-019 IDLE with WEnable=1 SHALL latch WCnt into a 10-bit remaining counter, drive FIFOADR=IN_EP_ADR, and go to W_ADR; with WCnt=0 it SHALL go directly to HOLD and issue no WDone.
REQ-020 W_ADR SHALL last one cycle (address settle), then go to W_DATA.
REQ-021 W_DATA with FullN=1 SHALL, on one edge, register FD_Out<=Send, FD_OE<=1, SLWR_N<=0, and WDone<=1, decrement remaining, and go to W_GAP; with FullN=0 it SHALL stall with SLWR_N=1 and WDone=0.
REQ-022 W_GAP SHALL hold SLWR_N=1 and WDone=0 for one cycle, so the gap between accepted words is at least 2 cycles; it then goes to W_DATA if remaining!=0, else to W_END.
REQ-023 W_END SHALL drive FD_OE<=0 and go to HOLD; the PKTEND behaviour is given in Configuration.
REQ-024 IDLE with REnable=1 (and WEnable=0) SHALL latch RCnt, drive FIFOADR=OUT_EP_ADR, and go to R_ADR; with RCnt=0 it SHALL go to HOLD and issue no RReady.
REQ-025 R_ADR SHALL last one cycle; R_OE SHALL drive SLOE_N<=0 for one cycle before any read.
REQ-026 R_DATA with EmptyN=1 SHALL, on one edge, register Receive<=FD_In, RReady<=1, SLRD_N<=0, decrement remaining, and go to R_GAP; with EmptyN=0 it SHALL stall with SLRD_N=1.
REQ-027 R_GAP SHALL hold SLRD_N=1 for one cycle, then go to R_DATA if remaining!=0; otherwise it SHALL set SLOE_N<=1 and go to HOLD.
REQ-028 HOLD SHALL wait until the enable of the finished direction is low, then go to IDLE; an enable held high SHALL NOT retrigger a transfer.
REQ-029 FD_OE=1 and SLOE_N=0 SHALL never be true in the same cycle.
REQ-030 WCnt/RCnt changes after the start sample SHALL be ignored; an enable dropping mid-transfer SHALL NOT abort it.

Reset
REQ-031 RST high SHALL immediately force: state IDLE, remaining=0, WDone=0, RReady=0, Receive=0, FD_Out=0, FD_OE=0, FIFOADR=OUT_EP_ADR, and all *_N strobes=1, including when a transfer is in progress.

Configuration
REQ-032 With USB_PKTEND_EN defined, W_END SHALL pulse PKTEND_N=0 for exactly one cycle to commit a short packet; without it, PKTEND_N SHALL be held at 1 and W_END SHALL still last one cycle.

Verification
REQ-033 WCnt=1, Send=16'h12FA, WEnable=1, FullN=1 -> one SLWR_N low with FD_Out=16'h12FA, one WDone, and (with USB_PKTEND_EN) one PKTEND_N pulse.
REQ-034 WCnt=10 with FullN low for cycles 5-12 -> exactly 10 SLWR_N pulses, none while FullN=0, and at least 2 cycles between pulses.
REQ-035 RCnt=3, FD_In=16'hA001/A002/A003 -> three RReady pulses with matching Receive values; SLOE_N low throughout; FD_OE=0.
REQ-036 WEnable and REnable rise in the same cycle -> the write completes first; the read starts only after WEnable is released and REnable is still high.
REQ-037 WCnt=0, and separately RCnt=0 -> no strobes and no WDone/RReady; the block returns to IDLE after the enable drops.
REQ-038 RST pulsed after the 4th of 10 write words -> all outputs at reset values in the same cycle, and a new transfer starts cleanly afterwards.

Source files
------------

// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge: client word stream <-> Cypress FX2 slave FIFO bridge.
// Writes go to the IN endpoint (device-to-host), reads come from the OUT
// endpoint (host-to-device). Every output is driven straight from a flop.
// Optional build macro: USB_PKTEND_EN -- pulse PKTEND_N in W_END so a short
// packet is committed to the host at the end of each write.
module usb_fifo_bridge #(
  parameter logic [1:0] OUT_EP_ADR = 2'b00,
  parameter logic [1:0] IN_EP_ADR  = 2'b10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wenable,
  input  logic [9:0]  i_wcnt,
  input  logic [15:0] i_send,
  output logic        o_wdone,
  input  logic        i_renable,
  input  logic [9:0]  i_rcnt,
  output logic [15:0] o_receive,
  output logic        o_rready,
  input  logic [15:0] i_fd_in,
  output logic [15:0] o_fd_out,
  output logic        o_fd_oe,
  output logic [1:0]  o_fifoadr,
  output logic        o_slwr_n,
  output logic        o_slrd_n,
  output logic        o_sloe_n,
  output logic        o_pktend_n,
  input  logic        i_fulln,
  input  logic        i_emptyn
);

  typedef enum logic [3:0] {
    IDLE, W_ADR, W_DATA, W_GAP, W_END, R_ADR, R_OE, R_DATA, R_GAP, HOLD
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_rem, w_rem_nxt;
  logic        r_dir_wr, w_dir_wr_nxt;
  logic        r_wdone, w_wdone_nxt;
  logic        r_rready, w_rready_nxt;
  logic [15:0] r_receive, w_receive_nxt;
  logic [15:0] r_fd_out, w_fd_out_nxt;
  logic        r_fd_oe, w_fd_oe_nxt;
  logic [1:0]  r_fifoadr, w_fifoadr_nxt;
  logic        r_slwr_n, w_slwr_n_nxt;
  logic        r_slrd_n, w_slrd_n_nxt;
  logic        r_sloe_n, w_sloe_n_nxt;
  logic        r_pktend_n, w_pktend_n_nxt;

  // Next-state and next-output decode; strobes and pulses fall back to
  // inactive every cycle, bus/address/OE settings hold unless changed.
  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_rem;
    w_dir_wr_nxt   = r_dir_wr;
    w_receive_nxt  = r_receive;
    w_fd_out_nxt   = r_fd_out;
    w_fd_oe_nxt    = r_fd_oe;
    w_fifoadr_nxt  = r_fifoadr;
    w_sloe_n_nxt   = r_sloe_n;
    w_wdone_nxt    = 1'b0;
    w_rready_nxt   = 1'b0;
    w_slwr_n_nxt   = 1'b1;
    w_slrd_n_nxt   = 1'b1;
    w_pktend_n_nxt = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_wenable) begin
          w_rem_nxt     = i_wcnt;
          w_dir_wr_nxt  = 1'b1;
          w_fifoadr_nxt = IN_EP_ADR;
          if (i_wcnt == 10'd0) w_state_nxt = HOLD;
          else                 w_state_nxt = W_ADR;
        end else if (i_renable) begin
          w_rem_nxt     = i_rcnt;
          w_dir_wr_nxt  = 1'b0;
          w_fifoadr_nxt = OUT_EP_ADR;
          if (i_rcnt == 10'd0) w_state_nxt = HOLD;
          else                 w_state_nxt = R_ADR;
        end
      end
      W_ADR: w_state_nxt = W_DATA;
      W_DATA: begin
        if (i_fulln) begin
          w_fd_out_nxt = i_send;
          w_fd_oe_nxt  = 1'b1;
          w_slwr_n_nxt = 1'b0;
          w_wdone_nxt  = 1'b1;
          w_rem_nxt    = r_rem - 10'd1;
          w_state_nxt  = W_GAP;
        end
      end
      W_GAP: begin
        if (r_rem != 10'd0) w_state_nxt = W_DATA;
        else                w_state_nxt = W_END;
      end
      W_END: begin
        w_fd_oe_nxt = 1'b0;
`ifdef USB_PKTEND_EN
        w_pktend_n_nxt = 1'b0;
`else
        w_pktend_n_nxt = 1'b1;
`endif
        w_state_nxt = HOLD;
      end
      R_ADR: w_state_nxt = R_OE;
      R_OE: begin
        w_sloe_n_nxt = 1'b0;
        w_state_nxt  = R_DATA;
      end
      R_DATA: begin
        if (i_emptyn) begin
          w_receive_nxt = i_fd_in;
          w_rready_nxt  = 1'b1;
          w_slrd_n_nxt  = 1'b0;
          w_rem_nxt     = r_rem - 10'd1;
          w_state_nxt   = R_GAP;
        end
      end
      R_GAP: begin
        if (r_rem != 10'd0) begin
          w_state_nxt = R_DATA;
        end else begin
          w_sloe_n_nxt = 1'b1;
          w_state_nxt  = HOLD;
        end
      end
      HOLD: begin
        // Only the direction that just finished gates the return to IDLE.
        if (r_dir_wr ? !i_wenable : !i_renable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, word counter and direction registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rem    <= 10'd0;
      r_dir_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_dir_wr <= w_dir_wr_nxt;
    end
  end

  // Output registers; reset parks the FX2 interface on the OUT endpoint.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdone    <= 1'b0;
      r_rready   <= 1'b0;
      r_receive  <= 16'd0;
      r_fd_out   <= 16'd0;
      r_fd_oe    <= 1'b0;
      r_fifoadr  <= OUT_EP_ADR;
      r_slwr_n   <= 1'b1;
      r_slrd_n   <= 1'b1;
      r_sloe_n   <= 1'b1;
      r_pktend_n <= 1'b1;
    end else begin
      r_wdone    <= w_wdone_nxt;
      r_rready   <= w_rready_nxt;
      r_receive  <= w_receive_nxt;
      r_fd_out   <= w_fd_out_nxt;
      r_fd_oe    <= w_fd_oe_nxt;
      r_fifoadr  <= w_fifoadr_nxt;
      r_slwr_n   <= w_slwr_n_nxt;
      r_slrd_n   <= w_slrd_n_nxt;
      r_sloe_n   <= w_sloe_n_nxt;
      r_pktend_n <= w_pktend_n_nxt;
    end
  end

  assign o_wdone    = r_wdone;
  assign o_rready   = r_rready;
  assign o_receive  = r_receive;
  assign o_fd_out   = r_fd_out;
  assign o_fd_oe    = r_fd_oe;
  assign o_fifoadr  = r_fifoadr;
  assign o_slwr_n   = r_slwr_n;
  assign o_slrd_n   = r_slrd_n;
  assign o_sloe_n   = r_sloe_n;
  assign o_pktend_n = r_pktend_n;

endmodule
